// File: rtl/test_status_pkg.sv
// Shared definitions for the tohost status monitor: verdict states, the
// pass code and the little-endian byte-merge used by every store target.
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_state_e;

  localparam logic [31:0] TOHOST_PASS = 32'h0000_0001;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Core store port as seen by the status monitor.
// Handshake: a store transfers on every rising edge where wr_valid && wr_ready;
// wr_ack pulses the cycle after a transferred store that hit the tohost word.
interface test_status_monitor_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ack;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb,
    input  wr_ready, wr_ack
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb,
    output wr_ready, wr_ack
  );
endinterface

// File: rtl/watchdog_counter.sv
// Free-running cycle counter that stops when frozen and flags the edge on
// which it reaches its limit.
module watchdog_counter #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_step;

  assign w_step = i_en && !i_freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry marks the counting edge that takes the count up to the limit.
  assign o_expire = w_step && (r_count == LIMIT);
  assign o_count  = r_count;

endmodule

// File: rtl/test_status_monitor.sv
// tohost responder: shadows the tohost word, decodes the program's verdict
// and raises TIMEOUT if the program never reports.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  test_status_monitor_if.slave bus,
  output logic [31:0]          tohost,
  output logic                 done,
  output logic                 passed,
  output logic                 failed,
  output logic                 timeout,
  output logic [30:0]          fail_test,
  output logic [CNT_W-1:0]     cycles,
  output status_state_e        dbg_state
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  status_state_e r_state;
  logic [31:0]   r_tohost;
  logic [30:0]   r_fail_test;
  logic          r_ack;
  logic          r_done;
  logic          r_passed;
  logic          r_failed;
  logic          r_timeout;

  logic          w_hit;
  logic [31:0]   w_new;
  logic          w_run;
  logic          w_expire;

  // Any byte offset within the tohost word counts as a hit.
  assign w_hit = bus.wr_valid
              && ((bus.wr_addr & WORD_MASK) == (TOHOST_ADDR & WORD_MASK))
              && (bus.wr_strb != 4'b0000);
  assign w_new = merge_bytes(r_tohost, bus.wr_data, bus.wr_strb);
  assign w_run = (r_state == ST_RUN);

  watchdog_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_en     (1'b1),
    .i_freeze (!w_run),
    .o_count  (cycles),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_tohost    <= '0;
      r_fail_test <= '0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_passed    <= 1'b0;
      r_failed    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_ack <= w_hit;
      if (w_hit) r_tohost <= w_new;
      case (r_state)
        ST_RUN: begin
          // A decoded verdict outranks watchdog expiry on the same edge.
          if (w_hit && (w_new == TOHOST_PASS)) begin
            r_state  <= ST_PASS;
            r_done   <= 1'b1;
            r_passed <= 1'b1;
          end else if (w_hit && w_new[0]) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_failed    <= 1'b1;
            r_fail_test <= w_new[31:1];
          end else if (w_expire) begin
            r_state   <= ST_TIMEOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.wr_ready = 1'b1;
  assign bus.wr_ack   = r_ack;
  assign tohost       = r_tohost;
  assign done         = r_done;
  assign passed       = r_passed;
  assign failed       = r_failed;
  assign timeout      = r_timeout;
  assign fail_test    = r_fail_test;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_test_status_monitor.sv
// Randomised and directed checks of test_status_monitor against a verdict
// model held in the bench.
module tb_test_status_monitor;
  import test_status_pkg::*;

  localparam int TO = 50;

  logic          clk;
  logic          rst;
  logic [31:0]   tohost;
  logic          done, passed, failed, timeout;
  logic [30:0]   fail_test;
  logic [31:0]   cycles;
  status_state_e dbg_state;

  test_status_monitor_if bus ();

  test_status_monitor #(
    .TOHOST_ADDR    (32'h0000_1000),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .tohost    (tohost),
    .done      (done),
    .passed    (passed),
    .failed    (failed),
    .timeout   (timeout),
    .fail_test (fail_test),
    .cycles    (cycles),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // verdict: 0 running, 1 pass, 2 fail, 3 timeout
  int          m_verdict;
  int          m_cycles;
  logic [31:0] m_tohost;
  logic [30:0] m_fail;
  logic        m_ack;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_verdict = 0;
      m_cycles  = 0;
      m_tohost  = 0;
      m_fail    = 0;
      m_ack     = 0;
      exp_q.delete();
    end else begin
      logic hit;
      hit = bus.wr_valid && ((bus.wr_addr >> 2) == (32'h1000 >> 2)) && (bus.wr_strb != 0);
      if (hit) begin
        for (int b = 0; b < 4; b++)
          if (bus.wr_strb[b]) m_tohost[8*b +: 8] = bus.wr_data[8*b +: 8];
        exp_q.push_back(m_tohost);
      end
      m_ack = hit;
      if (m_verdict == 0) begin
        m_cycles = m_cycles + 1;
        if (hit && m_tohost == 1) m_verdict = 1;
        else if (hit && m_tohost % 2 == 1) begin
          m_verdict = 2;
          m_fail    = 31'(m_tohost / 2);
        end else if (m_cycles == TO) m_verdict = 3;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("tohost",    tohost,    m_tohost);
      check("cycles",    cycles,    m_cycles);
      check("done",      done,      m_verdict != 0);
      check("passed",    passed,    m_verdict == 1);
      check("failed",    failed,    m_verdict == 2);
      check("timeout",   timeout,   m_verdict == 3);
      check("fail_test", fail_test, m_fail);
      check("wr_ack",    bus.wr_ack, m_ack);
      check("wr_ready",  bus.wr_ready, 1'b1);
      if (bus.wr_ack === 1'b1) begin
        if (exp_q.size() == 0) check("ack_without_hit", 1'b1, 1'b0);
        else check("ack_tohost", tohost, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.wr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the store is taken on the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    bus.wr_strb  = strb;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge before the first post-reset edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 3) return 32'h0;
    if (sel <= 6) return $urandom() & 32'hFFFF_FFFE;
    if (sel == 7) return 32'h1;
    if (sel == 8) return $urandom() | 32'h1;
    return $urandom();
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel <= 2) return 32'h1000;
    if (sel == 3) return 32'h1000 + 32'($urandom_range(1, 3));
    if (sel == 4) return 32'h1004;
    return $urandom();
  endfunction

  // ---------------- directed + random sequences ----------------
  initial begin
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_strb  = '0;
    #1;
    check("reset_tohost", tohost, 32'h0);
    check("reset_done",   done,   1'b0);
    check("reset_cycles", cycles, 32'd0);
    check("reset_ack",    bus.wr_ack, 1'b0);
    #20;

    // pass: stores of 0 then 1, the 1 taken on edge 21
    do_reset();
    idle(19);
    store(32'h1000, 32'h0, 4'hF);
    check("pass_ack0", bus.wr_ack, 1'b1);
    store(32'h1000, 32'h1, 4'hF);
    check("pass_ack1",    bus.wr_ack, 1'b1);
    check("pass_passed",  passed,    1'b1);
    check("pass_cycles",  cycles,    32'd21);
    check("pass_failtst", fail_test, 31'd0);
    idle(3);
    check("pass_frozen",  cycles,    32'd21);

    // fail, then a late pass code must not override the verdict
    do_reset();
    idle(2);
    store(32'h1000, 32'h7, 4'hF);
    check("fail_failed", failed,    1'b1);
    check("fail_test3",  fail_test, 31'd3);
    store(32'h1000, 32'h1, 4'hF);
    check("fail_sticky", failed, 1'b1);
    check("fail_nopass", passed, 1'b0);
    check("fail_tohost", tohost, 32'h1);

    // byte lanes
    do_reset();
    store(32'h1000, 32'h0000_0300, 4'b0010);
    check("lane_tohost", tohost, 32'h300);
    check("lane_run",    done,   1'b0);
    store(32'h1000, 32'h0, 4'hF);
    store(32'h1000, 32'hFFFF_FF01, 4'b0001);
    check("lane_pass",   passed, 1'b1);

    // non-hits and empty-strobe stores
    do_reset();
    store(32'h1004, 32'h1, 4'hF);
    check("nohit_ack_1004", bus.wr_ack, 1'b0);
    store(32'h0FFC, 32'h1, 4'hF);
    check("nohit_ack_0ffc", bus.wr_ack, 1'b0);
    store(32'h1000, 32'h1, 4'h0);
    check("nohit_ack_strb0", bus.wr_ack, 1'b0);
    check("nohit_run", done, 1'b0);

    // timeout
    do_reset();
    idle(TO);
    check("to_timeout", timeout, 1'b1);
    check("to_cycles",  cycles,  32'd50);
    idle(5);
    check("to_hold",    cycles,  32'd50);

    // tie on the expiry edge, then a mid-cycle reset
    do_reset();
    idle(TO - 1);
    store(32'h1000, 32'h1, 4'hF);
    check("tie_passed",  passed,  1'b1);
    check("tie_timeout", timeout, 1'b0);
    check("tie_cycles",  cycles,  32'd50);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_done",   done,   1'b0);
    check("async_passed", passed, 1'b0);
    check("async_tohost", tohost, 32'h0);
    check("async_cycles", cycles, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    idle(5);
    check("resume_cycles", cycles, 32'd5);
    check("resume_run",    done,   1'b0);

    // randomised traffic
    for (int run = 0; run < 8; run++) begin
      int len;
      do_reset();
      len = $urandom_range(20, 80);
      for (int c = 0; c < len; c++) begin
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_addr  = rand_addr();
        bus.wr_data  = rand_data();
        bus.wr_strb  = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      idle(2);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
